// File: rtl/xeng_pkg.sv
// Shared X-engine types: antenna index, sample word and write-side FSM encoding.
// Default widths match a 16-antenna, 8-bit-sample build; modules size ports from their own parameters.
package xeng_pkg;

   function automatic int log2(input int value);
      int res;
      res = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) res = i + 1;
      end
      return res;
   endfunction

   localparam int DEF_N_ANTS     = 16;
   localparam int DEF_DATA_WIDTH = 8;
   localparam int DEF_ANT_BITS   = log2(DEF_N_ANTS);

   typedef logic [DEF_ANT_BITS-1:0]   ant_idx_t;
   typedef logic [DEF_DATA_WIDTH-1:0] sample_t;

   typedef enum logic {
      WR_IDLE = 1'b0,
      WR_FILL = 1'b1
   } wr_state_e;

endpackage

// File: rtl/xeng_ant_dbuf_if.sv
// Sample-write, baseline-read and operand-output bundle of the antenna double buffer.
// master = order generator / sample source side, slave = the buffer itself.
interface xeng_ant_dbuf_if #(
   parameter int N_ANTS     = 16,
   parameter int DATA_WIDTH = 8
);
   import xeng_pkg::*;
   localparam int ANT_BITS = log2(N_ANTS);

   logic                  sync;
   logic                  din_valid;
   logic [DATA_WIDTH-1:0] din;
   logic                  rd_en;
   logic [ANT_BITS-1:0]   ant_a;
   logic [ANT_BITS-1:0]   ant_b;
   logic                  buf_sel;
   logic                  last_triangle;
   logic [DATA_WIDTH-1:0] dout_a;
   logic [DATA_WIDTH-1:0] dout_b;
   logic                  dout_valid;
   logic                  wr_bank;
   logic                  window_done;
   logic                  rd_collision;

   modport master (
      output sync, din_valid, din, rd_en, ant_a, ant_b, buf_sel, last_triangle,
      input  dout_a, dout_b, dout_valid, wr_bank, window_done, rd_collision
   );

   modport slave (
      input  sync, din_valid, din, rd_en, ant_a, ant_b, buf_sel, last_triangle,
      output dout_a, dout_b, dout_valid, wr_bank, window_done, rd_collision
   );
endinterface

// File: rtl/xeng_dbuf_ram.sv
// Ping-pong sample RAM: one write port, two read-first registered read ports, depth 2*N_ANTS.
// Read data appears the edge after a read enable; no flow control, output holds when not reading.
module xeng_dbuf_ram
   import xeng_pkg::*;
#(
   parameter int N_ANTS     = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       wr_en,
   input  logic                       wr_bank,
   input  logic [log2(N_ANTS)-1:0]    wr_addr,
   input  logic [DATA_WIDTH-1:0]      wr_dat,
   input  logic                       rd_a_en,
   input  logic                       rd_a_bank,
   input  logic [log2(N_ANTS)-1:0]    rd_a_addr,
   output logic [DATA_WIDTH-1:0]      rd_a_dat,
   input  logic                       rd_b_en,
   input  logic                       rd_b_bank,
   input  logic [log2(N_ANTS)-1:0]    rd_b_addr,
   output logic [DATA_WIDTH-1:0]      rd_b_dat
);
   localparam int DEPTH = 2 * N_ANTS;

   // One array per read port so each maps onto a plain simple-dual-port block RAM.
   logic [DATA_WIDTH-1:0] mem_a [DEPTH];
   logic [DATA_WIDTH-1:0] mem_b [DEPTH];
   logic [DATA_WIDTH-1:0] rd_a_q, rd_a_d;
   logic [DATA_WIDTH-1:0] rd_b_q, rd_b_d;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_a[{wr_bank, wr_addr}] <= wr_dat;
         mem_b[{wr_bank, wr_addr}] <= wr_dat;
      end
   end

   always_comb begin
      rd_a_d = rd_a_q;
      rd_b_d = rd_b_q;
      if (rd_a_en) rd_a_d = mem_a[{rd_a_bank, rd_a_addr}];
      if (rd_b_en) rd_b_d = mem_b[{rd_b_bank, rd_b_addr}];
   end

   always_ff @(posedge clk) begin
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
   end

   assign rd_a_dat = rd_a_q;
   assign rd_b_dat = rd_b_q;
endmodule

// File: rtl/xeng_ant_dbuf.sv
// Double-buffered antenna sample store feeding the cross-multiply stage with A/B operands.
// Reads return 2 edges after sampling; both sides accept one beat per cycle with no backpressure.
module xeng_ant_dbuf
   import xeng_pkg::*;
#(
   parameter int N_ANTS     = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   xeng_ant_dbuf_if.slave bus
);
   localparam int                  ANT_BITS = log2(N_ANTS);
   localparam logic [ANT_BITS-1:0] LAST_ANT = ANT_BITS'(N_ANTS - 1);

   wr_state_e             state_q, state_d;
   logic [ANT_BITS-1:0]   wr_ant_q, wr_ant_d;
   logic                  wr_bank_q, wr_bank_d;
   logic                  window_done_q, window_done_d;
   logic                  w_vld_q, w_vld_d;
   logic                  w_bank_q, w_bank_d;
   logic [ANT_BITS-1:0]   w_addr_q, w_addr_d;
   logic [DATA_WIDTH-1:0] w_dat_q, w_dat_d;

   logic                  s1_vld_q, s1_vld_d;
   logic                  s1_bank_a_q, s1_bank_a_d;
   logic                  s1_bank_b_q, s1_bank_b_d;
   logic [ANT_BITS-1:0]   s1_addr_a_q, s1_addr_a_d;
   logic [ANT_BITS-1:0]   s1_addr_b_q, s1_addr_b_d;
   logic                  s2_vld_q, s2_vld_d;
   logic                  s2_col_q, s2_col_d;
   logic                  dout_valid_q, dout_valid_d;
   logic                  rd_collision_q, rd_collision_d;
   logic [DATA_WIDTH-1:0] dout_a_q, dout_a_d;
   logic [DATA_WIDTH-1:0] dout_b_q, dout_b_d;
   logic [DATA_WIDTH-1:0] ram_a_dat, ram_b_dat;

   // The write is staged one cycle so it meets the RAM on the same edge as a read
   // sampled alongside it, which makes same-cycle collisions read the old word.
   always_comb begin
      state_d       = state_q;
      wr_ant_d      = wr_ant_q;
      wr_bank_d     = wr_bank_q;
      window_done_d = 1'b0;
      w_vld_d       = 1'b0;
      w_bank_d      = wr_bank_q;
      w_addr_d      = wr_ant_q;
      w_dat_d       = bus.din;
      if (bus.sync) begin
         state_d   = WR_FILL;
         wr_bank_d = 1'b0;
         w_bank_d  = 1'b0;
         w_addr_d  = '0;
         w_vld_d   = bus.din_valid;
         wr_ant_d  = bus.din_valid ? ANT_BITS'(1) : '0;
      end else if (state_q == WR_FILL && bus.din_valid) begin
         w_vld_d  = 1'b1;
         wr_ant_d = wr_ant_q + ANT_BITS'(1);
         if (wr_ant_q == LAST_ANT) begin
            wr_bank_d     = ~wr_bank_q;
            window_done_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= WR_IDLE;
         wr_ant_q      <= '0;
         wr_bank_q     <= 1'b0;
         window_done_q <= 1'b0;
         w_vld_q       <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_ant_q      <= wr_ant_d;
         wr_bank_q     <= wr_bank_d;
         window_done_q <= window_done_d;
         w_vld_q       <= w_vld_d;
      end
   end

   always_comb begin
      s1_vld_d       = bus.rd_en;
      s1_bank_a_d    = bus.buf_sel;
      s1_bank_b_d    = bus.buf_sel ^ bus.last_triangle;
      s1_addr_a_d    = bus.ant_a;
      s1_addr_b_d    = bus.ant_b;
      s2_vld_d       = s1_vld_q;
      s2_col_d       = s1_vld_q && w_vld_q &&
                       ((s1_bank_a_q == w_bank_q && s1_addr_a_q == w_addr_q) ||
                        (s1_bank_b_q == w_bank_q && s1_addr_b_q == w_addr_q));
      dout_valid_d   = s2_vld_q;
      rd_collision_d = s2_col_q;
      dout_a_d       = s2_vld_q ? ram_a_dat : dout_a_q;
      dout_b_d       = s2_vld_q ? ram_b_dat : dout_b_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vld_q       <= 1'b0;
         s2_vld_q       <= 1'b0;
         s2_col_q       <= 1'b0;
         dout_valid_q   <= 1'b0;
         rd_collision_q <= 1'b0;
         dout_a_q       <= '0;
         dout_b_q       <= '0;
      end else begin
         s1_vld_q       <= s1_vld_d;
         s2_vld_q       <= s2_vld_d;
         s2_col_q       <= s2_col_d;
         dout_valid_q   <= dout_valid_d;
         rd_collision_q <= rd_collision_d;
         dout_a_q       <= dout_a_d;
         dout_b_q       <= dout_b_d;
      end
   end

   always_ff @(posedge clk) begin
      w_bank_q    <= w_bank_d;
      w_addr_q    <= w_addr_d;
      w_dat_q     <= w_dat_d;
      s1_bank_a_q <= s1_bank_a_d;
      s1_bank_b_q <= s1_bank_b_d;
      s1_addr_a_q <= s1_addr_a_d;
      s1_addr_b_q <= s1_addr_b_d;
   end

   xeng_dbuf_ram #(
      .N_ANTS     (N_ANTS),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_ram (
      .clk       (clk),
      .wr_en     (w_vld_q),
      .wr_bank   (w_bank_q),
      .wr_addr   (w_addr_q),
      .wr_dat    (w_dat_q),
      .rd_a_en   (s1_vld_q),
      .rd_a_bank (s1_bank_a_q),
      .rd_a_addr (s1_addr_a_q),
      .rd_a_dat  (ram_a_dat),
      .rd_b_en   (s1_vld_q),
      .rd_b_bank (s1_bank_b_q),
      .rd_b_addr (s1_addr_b_q),
      .rd_b_dat  (ram_b_dat)
   );

   assign bus.dout_a       = dout_a_q;
   assign bus.dout_b       = dout_b_q;
   assign bus.dout_valid   = dout_valid_q;
   assign bus.wr_bank      = wr_bank_q;
   assign bus.window_done  = window_done_q;
   assign bus.rd_collision = rd_collision_q;
endmodule

// File: tb/tb_xeng_ant_dbuf.sv
// Directed + randomized bench for xeng_ant_dbuf against a window-count reference model.
module tb_xeng_ant_dbuf;
   import xeng_pkg::*;

   localparam int N  = 16;
   localparam int DW = 8;
   localparam int AB = log2(N);

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   xeng_ant_dbuf_if #(.N_ANTS(N), .DATA_WIDTH(DW)) bus ();
   xeng_ant_dbuf #(.N_ANTS(N), .DATA_WIDTH(DW)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   typedef struct packed {
      logic          vld;
      logic          col;
      logic          ka;
      logic          kb;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
   } rd_res_t;

   // Reference: the k-th accepted sample after a sync lands in bank (k/N)%2, address k%N.
   logic [DW-1:0] mem [2][N];
   bit            known [2][N];
   bit            filling;
   int            wcount;
   rd_res_t       pipe1, pipe2;
   logic [DW-1:0] exp_a, exp_b;
   bit            exp_ka, exp_kb, exp_vld, exp_col, exp_done, exp_bank;
   int            n_pass, n_fail, n_total;
   int            vld_seen;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      rd_res_t cur;
      bit      wr;
      int      wb, wa, ba, bb;
      @(posedge clk);
      if (!rst_n) begin
         filling  = 0;
         wcount   = 0;
         pipe1    = '0;
         pipe2    = '0;
         exp_vld  = 0;
         exp_col  = 0;
         exp_done = 0;
         exp_a    = '0;
         exp_b    = '0;
         exp_ka   = 1;
         exp_kb   = 1;
      end else begin
         if (bus.sync) begin
            wcount  = 0;
            filling = 1;
         end
         wr = filling && bus.din_valid;
         wb = (wcount / N) % 2;
         wa = wcount % N;
         cur = '0;
         if (bus.rd_en) begin
            ba      = bus.buf_sel ? 1 : 0;
            bb      = (bus.buf_sel ^ bus.last_triangle) ? 1 : 0;
            cur.vld = 1'b1;
            cur.a   = mem[ba][bus.ant_a];
            cur.ka  = known[ba][bus.ant_a];
            cur.b   = mem[bb][bus.ant_b];
            cur.kb  = known[bb][bus.ant_b];
            cur.col = wr && ((ba == wb && int'(bus.ant_a) == wa) ||
                             (bb == wb && int'(bus.ant_b) == wa));
         end
         exp_vld = pipe2.vld;
         exp_col = pipe2.col;
         if (pipe2.vld) begin
            exp_a  = pipe2.a;
            exp_b  = pipe2.b;
            exp_ka = pipe2.ka;
            exp_kb = pipe2.kb;
         end
         pipe2    = pipe1;
         pipe1    = cur;
         exp_done = 0;
         if (wr) begin
            mem[wb][wa]   = bus.din;
            known[wb][wa] = 1;
            wcount++;
            exp_done = (wcount % N == 0);
         end
      end
      exp_bank = filling && ((wcount / N) % 2 == 1);
      #1;
      vld_seen += bus.dout_valid ? 1 : 0;
      check("dout_valid",   32'(bus.dout_valid),   32'(exp_vld));
      check("rd_collision", 32'(bus.rd_collision), 32'(exp_col));
      check("window_done",  32'(bus.window_done),  32'(exp_done));
      check("wr_bank",      32'(bus.wr_bank),      32'(exp_bank));
      if (exp_ka) check("dout_a", 32'(bus.dout_a), 32'(exp_a));
      if (exp_kb) check("dout_b", 32'(bus.dout_b), 32'(exp_b));
   endtask

   task automatic cyc(input bit s, input bit dv, input int d, input bit re,
                      input int a, input int b, input bit bs, input bit lt);
      bus.sync          = s;
      bus.din_valid     = dv;
      bus.din           = DW'(d);
      bus.rd_en         = re;
      bus.ant_a         = AB'(a);
      bus.ant_b         = AB'(b);
      bus.buf_sel       = bs;
      bus.last_triangle = lt;
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic fill(input int base);
      for (int k = 0; k < N; k++) cyc(0, 1, base + k, 0, 0, 0, 0, 0);
   endtask

   initial begin
      int oa, ob, reads;
      n_pass = 0; n_fail = 0; n_total = 0; vld_seen = 0;
      filling = 0; wcount = 0; pipe1 = '0; pipe2 = '0;
      rst_n = 1'b0;
      idle(3);
      rst_n = 1'b1;

      // Writes before the first sync are dropped.
      for (int k = 0; k < 3; k++) cyc(0, 1, 8'hEE, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 0, 0, 0);

      fill(8'h10);
      check("fill_done_pulse", 32'(bus.window_done), 32'd1);
      check("fill_wr_bank", 32'(bus.wr_bank), 32'd1);
      for (int k = 0; k < N; k++) cyc(0, 0, 0, 1, k, k, 0, 0);
      idle(2);
      check("fill_last_a", 32'(bus.dout_a), 32'h1F);
      check("fill_last_b", 32'(bus.dout_b), 32'h1F);

      fill(8'h50);
      fill(8'hA0);
      for (int k = 0; k < N; k++) begin
         cyc(0, 1, 8'hB0 + k, (k == 5 || k == 6), 5, 5, 1, 0);
         if (k == 7) begin
            check("col_old_a", 32'(bus.dout_a), 32'h55);
            check("col_flag",  32'(bus.rd_collision), 32'd1);
         end
         if (k == 8) begin
            check("col_new_a", 32'(bus.dout_a), 32'hB5);
            check("col_clear", 32'(bus.rd_collision), 32'd0);
         end
      end

      cyc(0, 0, 0, 1, 9, 2, 0, 1);
      idle(2);
      check("lt_a_prev_bank", 32'(bus.dout_a), 32'hA9);
      check("lt_b_cur_bank",  32'(bus.dout_b), 32'hB2);

      for (int k = 0; k < 7; k++) cyc(0, 1, 8'hC0 + k, 0, 0, 0, 0, 0);
      cyc(1, 1, 8'h3C, 0, 0, 0, 0, 0);
      check("msync_wr_bank", 32'(bus.wr_bank), 32'd0);
      cyc(0, 0, 0, 1, 0, 0, 0, 0);
      idle(2);
      check("msync_addr0", 32'(bus.dout_a), 32'h3C);
      for (int k = 1; k < N; k++) cyc(0, 1, 8'hD0 + k, 0, 0, 0, 0, 0);
      check("msync_done_after_15", 32'(bus.window_done), 32'd1);

      cyc(0, 0, 0, 1, 3, 3, 0, 0);
      cyc(0, 0, 0, 1, 4, 4, 0, 0);
      rst_n = 1'b0;
      idle(1);
      rst_n = 1'b1;
      check("rst_vld_0", 32'(bus.dout_valid), 32'd0);
      idle(1);
      check("rst_vld_1", 32'(bus.dout_valid), 32'd0);
      for (int k = 0; k < 3; k++) cyc(0, 1, 8'hEE, 0, 0, 0, 0, 0);
      check("rst_wr_bank", 32'(bus.wr_bank), 32'd0);
      cyc(1, 0, 0, 1, 0, 0, 0, 0);
      idle(2);
      check("rst_write_ignored", 32'(bus.dout_a), 32'h3C);

      // Four windows at full rate on both sides; reads walk a baseline triangle.
      oa = 0; ob = 0; reads = 0; vld_seen = 0;
      for (int c = 0; c < 4 * N; c++) begin
         cyc(0, 1, int'($urandom_range(0, 255)), 1, oa, ob,
             ((wcount / N) % 2) == 0, 1'($urandom_range(0, 1)));
         reads++;
         ob++;
         if (ob > oa) begin
            ob = 0;
            oa = (oa + 1) % N;
         end
      end
      idle(2);
      check("tput_reads", 32'(vld_seen), 32'(reads));
      for (int k = 0; k < N; k++) cyc(0, 0, 0, 1, k, N - 1 - k, 1, 1);
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

// File: doc/xeng_ant_dbuf.md
# xeng_ant_dbuf

Double-buffered antenna sample store for the X-engine, downstream of the baseline order generator. Incoming per-antenna samples are written into one bank of a ping-pong buffer while baseline reads pull antenna pairs from the bank selected by the order generator. For each baseline the block delivers the two operand samples, dout_a and dout_b, to the cross-multiply stage. Last-triangle baselines take their A operand from the previous window's bank.

## Interface
Parameters:
- N_ANTS, 16, antennas per window; power of two, 4 or more
- DATA_WIDTH, 8, bits per antenna sample (complex packed)
- ANT_BITS, log2(N_ANTS), derived localparam, not overridable

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- sync  in  1  window realignment pulse; same cycle as the order generator's sync
- din_valid  in  1  write strobe
- din  in  DATA_WIDTH  sample for the next antenna in write order
- rd_en  in  1  baseline read request (order generator's en, delayed to match its output register)
- ant_a  in  ANT_BITS  A antenna index
- ant_b  in  ANT_BITS  B antenna index
- buf_sel  in  1  bank for the A operand
- last_triangle  in  1  1 = A operand from the previous window
- dout_a  out  DATA_WIDTH  A operand sample
- dout_b  out  DATA_WIDTH  B operand sample
- dout_valid  out  1  dout_a/dout_b qualifier
- wr_bank  out  1  bank currently being written
- window_done  out  1  one-cycle pulse when a bank fill completes
- rd_collision  out  1  one-cycle flag: a read addressed the live write location

## Operation
- Write side: counter wr_ant, ANT_BITS wide.
  - Each cycle din_valid=1 writes din to bank wr_bank, address wr_ant, then wr_ant increments.
  - When wr_ant == N_ANTS-1 is written, wr_ant wraps to 0, wr_bank toggles, and window_done pulses next cycle.
- Write-side state: IDLE, FILL.
  - rst_n=0 forces IDLE with wr_ant=0 and wr_bank=0.
  - In IDLE, writes are ignored until the first sync. sync moves IDLE to FILL.
  - In FILL, sync resets wr_ant=0 and wr_bank=0. Any write in the same cycle as sync goes to bank 0, address 0, and wr_ant becomes 1.
- Read side bank selection:
  - A operand bank = buf_sel; B operand bank = buf_sel XOR last_triangle. B therefore always reads the current window's bank.
  - Address = ant_a for port A, ant_b for port B.
- Collisions: RAM is read-first. A same-cycle read and write to the same bank and address returns the old word.
  - rd_collision asserts for that read, aligned with its dout_valid.
  - The flag covers both ports, ORed.
- rd_en=0: no read is issued, and dout_a/dout_b hold their last value.
- rd_en and din_valid are independent. Both may be high every cycle; full throughput is required on both sides.

## Timing
- Read latency is 2 cycles. Inputs sampled at edge T give dout_a, dout_b, dout_valid and rd_collision valid after edge T+2.
  - Stage 1 registers the addresses and bank selects.
  - Stage 2 registers the RAM output.
- A write at edge T is visible to reads sampled at edge T+1 or later.
- window_done asserts the cycle after the last write of a window. wr_bank shows the new value in that same cycle.
- Reset values: dout_a=0, dout_b=0, dout_valid=0, wr_bank=0, window_done=0, rd_collision=0.
  - RAM contents are not reset.
  - Pipeline valids are cleared, so a reset mid-read drops in-flight reads.
- sync does not flush the read pipeline; reads in flight complete normally.

## Structure
- Shared package xeng_pkg holds:
  - log2 function (clog2 fallback)
  - ant_idx_t (ANT_BITS)
  - sample_t (DATA_WIDTH)
  - write-FSM state encoding
- Sub-module xeng_dbuf_ram:
  - one write port (bank, addr, data, we) and two independent registered read ports (bank, addr)
  - depth 2*N_ANTS, address = {bank, ant}
  - implemented as two copies of a simple dual-port BRAM-inferable array, one per read port
- Top level contains the write FSM and counter, the read-select pipeline, and collision compare logic.

## Test plan
- Basic fill:
  - Stimulus: after reset and sync, write din=0x10+k for k=0..15. Then read ant_a=ant_b=k with buf_sel=0, last_triangle=0.
  - Response: dout_a = dout_b = 0x10+k, valid 2 cycles after each read. wr_bank=1 and window_done pulses once after k=15.
- Ping-pong with last triangle:
  - Stimulus: fill bank 0 with 0xA0+k, then bank 1 with 0xB0+k. Read ant_a=9, ant_b=2, buf_sel=0, last_triangle=1.
  - Response: dout_a=0xA9 (bank 0), dout_b=0xB2 (bank 1).
- Collision:
  - Stimulus: during the bank-1 fill, read bank 1 at address 5 on the same edge that writes 0xB5 there. Old content is 0x55.
  - Response: dout=0x55 and rd_collision=1. A repeat read one cycle later gives 0xB5 with rd_collision=0.
- Mid-window sync:
  - Stimulus: write 7 samples, pulse sync with din_valid=1 and din=0x3C.
  - Response: bank 0, address 0 = 0x3C; wr_ant=1; wr_bank=0; no window_done.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 for one cycle with two reads in flight.
  - Response: dout_valid=0 on the next two cycles, wr_bank=0, and writes are ignored until the next sync.
- Throughput:
  - Stimulus: drive rd_en and din_valid continuously for 4 windows, with addresses taken from a bl_order_gen model.
  - Response: one dout_valid per rd_en cycle and no dropped writes; every output matches the reference model.
